// File: rtl/rename_pkg.sv
// Shared types and constants for the rename controller and its map-table glue.
package rename_pkg;
    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;
    localparam logic [4:0] ZERO_REG  = 5'd31;
    localparam int         ARCH_REGS = 32;
endpackage

// File: rtl/rename_controller_if.sv
// Dispatch, commit and map-table signal bundle; the controller takes the slave side.
interface rename_controller_if #(parameter int TAG_W = 6);
    logic             dispatch_valid_i;
    logic             dispatch_has_dest_i;
    logic [4:0]       dispatch_dest_i;
    logic             dispatch_ready_o;
    logic [TAG_W-1:0] dispatch_tag_o;
    logic             commit_valid_i;
    logic             commit_has_dest_i;
    logic [4:0]       commit_dest_i;
    logic             flush_i;
    logic [4:0]       mt_write_addr_o;
    logic [TAG_W-1:0] mt_write_data_o;
    logic             mt_reg_write_o;
    logic [4:0]       mt_commit_addr_o;
    logic [TAG_W-1:0] mt_commit_data_i;
    logic [31:0]      mt_resets_o;
    logic             mt_flush_o;
    logic             commit_err_o;

    modport master (
        output dispatch_valid_i, dispatch_has_dest_i, dispatch_dest_i,
               commit_valid_i, commit_has_dest_i, commit_dest_i, flush_i, mt_commit_data_i,
        input  dispatch_ready_o, dispatch_tag_o, mt_write_addr_o, mt_write_data_o,
               mt_reg_write_o, mt_commit_addr_o, mt_resets_o, mt_flush_o, commit_err_o
    );
    modport slave (
        input  dispatch_valid_i, dispatch_has_dest_i, dispatch_dest_i,
               commit_valid_i, commit_has_dest_i, commit_dest_i, flush_i, mt_commit_data_i,
        output dispatch_ready_o, dispatch_tag_o, mt_write_addr_o, mt_write_data_o,
               mt_reg_write_o, mt_commit_addr_o, mt_resets_o, mt_flush_o, commit_err_o
    );
endinterface

// File: rtl/rob_ptr_counter.sv
// Wrapping ROB pointer with increment enable and synchronous clear.
module rob_ptr_counter #(
    parameter int DEPTH = 32,
    parameter int W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
endmodule

// File: rtl/rename_controller.sv
// Allocates ROB tags at dispatch, drives map-table writes/clears, and sequences flush recovery.
module rename_controller
    import rename_pkg::*;
#(
    parameter int ROBsize       = 32,
    parameter int mapValueSize  = $clog2(ROBsize + 1),
    parameter int RecoverCycles = 2
) (
    input logic               clk,
    input logic               reset,
    rename_controller_if.slave bus
);
    localparam int PTR_W = (ROBsize > 1) ? $clog2(ROBsize) : 1;
    typedef logic [mapValueSize-1:0] tag_t;

    state_t           state;
    logic [3:0]       rcnt;
    tag_t             count;
    logic [PTR_W-1:0] head, tail;
    logic             flush_q, err_q;
    tag_t             head_tag, tail_tag;
    logic             run, ready, accept, commit_ok, commit_hit;

    // Tags are pointer+1 so that tag 0 can keep meaning "value in register file".
    assign head_tag = tag_t'(head) + tag_t'(1);
    assign tail_tag = tag_t'(tail) + tag_t'(1);

    assign run        = (state == RUN) && !bus.flush_i && !reset;
    assign ready      = run && (count < tag_t'(ROBsize));
    assign accept     = bus.dispatch_valid_i && ready;
    assign commit_ok  = run && bus.commit_valid_i && (count != '0);
    // Clear only if no younger dispatch has remapped the register since.
    assign commit_hit = commit_ok && bus.commit_has_dest_i && (bus.commit_dest_i != ZERO_REG) &&
                        (bus.mt_commit_data_i == head_tag);

    assign bus.dispatch_ready_o = ready;
    assign bus.dispatch_tag_o   = tail_tag;
    assign bus.mt_write_addr_o  = reset ? '0 : bus.dispatch_dest_i;
    assign bus.mt_write_data_o  = reset ? '0 : tail_tag;
    assign bus.mt_reg_write_o   = accept && bus.dispatch_has_dest_i && (bus.dispatch_dest_i != ZERO_REG);
    assign bus.mt_commit_addr_o = reset ? '0 : bus.commit_dest_i;
    assign bus.mt_resets_o      = commit_hit ? (32'd1 << bus.commit_dest_i) : 32'd0;
    assign bus.mt_flush_o       = flush_q && !reset;
    assign bus.commit_err_o     = err_q;

    rob_ptr_counter #(.DEPTH(ROBsize), .W(PTR_W)) u_head (
        .clk(clk), .reset(reset), .clr(bus.flush_i), .inc(commit_ok), .ptr(head)
    );
    rob_ptr_counter #(.DEPTH(ROBsize), .W(PTR_W)) u_tail (
        .clk(clk), .reset(reset), .clr(bus.flush_i), .inc(accept), .ptr(tail)
    );

    always_ff @(posedge clk) begin
        if (reset || bus.flush_i)
            count <= '0;
        else if (accept && !commit_ok)
            count <= count + tag_t'(1);
        else if (!accept && commit_ok)
            count <= count - tag_t'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (run && bus.commit_valid_i && (count == '0))
            err_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            rcnt    <= '0;
            flush_q <= 1'b0;
        end else if (bus.flush_i) begin
            state   <= FLUSH;
            flush_q <= 1'b1;
        end else begin
            case (state)
                FLUSH: begin
                    state   <= RECOVER;
                    rcnt    <= 4'(RecoverCycles);
                    flush_q <= 1'b0;
                end
                RECOVER: begin
                    rcnt <= rcnt - 4'd1;
                    if (rcnt <= 4'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
